// File: rtl/uart_cmd_regs.sv
// UART command parser with an addressed 8-bit register bank and a one-entry reply queue.
// Define UART_CMD_REGS_CHECKSUM_EN to require a 4th CSUM byte (ADDR ^ DATA) on write frames.
module uart_cmd_regs #(
    parameter int NUM_REGS     = 4,
    parameter int TIMEOUT_CLKS = 250000
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_RX_DV,
    input  logic [7:0]            i_RX_Byte,
    input  logic                  i_TX_Active,
    output logic                  o_TX_DV,
    output logic [7:0]            o_TX_Byte,
    output logic [8*NUM_REGS-1:0] o_Regs,
    output logic                  o_Wr_Strobe,
    output logic [7:0]            o_Wr_Addr,
    output logic                  o_Timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CLKS);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_W_ADDR = 3'd1;
    localparam logic [2:0] ST_W_DATA = 3'd2;
    localparam logic [2:0] ST_R_ADDR = 3'd3;
`ifdef UART_CMD_REGS_CHECKSUM_EN
    localparam logic [2:0] ST_W_CSUM = 3'd4;
`endif

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h45;

    logic [2:0]       state_q, state_d;
    logic [7:0]       addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       regs_d [NUM_REGS];
    logic             pend_q, pend_d;
    logic             tx_dv_q, tx_dv_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             wr_strobe_q, wr_strobe_d;
    logic [7:0]       wr_addr_q, wr_addr_d;
    logic             timeout_q, timeout_d;
`ifdef UART_CMD_REGS_CHECKSUM_EN
    logic [7:0]       data_q, data_d;
`endif

    logic [2:0] eff_state;
    logic       timed_out;
    logic       write_en;
    logic [7:0] write_data;
    logic       queue_en;
    logic [7:0] queue_byte;
    logic [7:0] rd_data;

    function automatic logic addr_ok(input logic [7:0] a);
        return {1'b0, a} < 9'(NUM_REGS);
    endfunction

    // Read mux addressed by the incoming byte; out-of-range addresses never select.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_RX_Byte == 8'(i)) rd_data = regs_q[i];
        end
    end

    // NOTE: every signal assigned below gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        regs_d      = regs_q;
        pend_d      = pend_q;
        tx_dv_d     = 1'b0;
        tx_byte_d   = tx_byte_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        timeout_d   = timeout_q;
        write_en    = 1'b0;
        write_data  = 8'h00;
        queue_en    = 1'b0;
        queue_byte  = 8'h00;
`ifdef UART_CMD_REGS_CHECKSUM_EN
        data_d      = data_q;
`endif

        // An expiring frame drops back to IDLE first, so a coincident byte opens a new frame.
        timed_out = (state_q != ST_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CLKS - 1));
        eff_state = timed_out ? ST_IDLE : state_q;
        state_d   = eff_state;
        if (timed_out) timeout_d = 1'b1;
        cnt_d = (eff_state == ST_IDLE) ? '0 : cnt_q + 1'b1;

        if (i_RX_DV) begin
            cnt_d = '0;
            case (eff_state)
                ST_IDLE: begin
                    if (i_RX_Byte == CMD_WRITE) begin
                        state_d = ST_W_ADDR;
                    end else if (i_RX_Byte == CMD_READ) begin
                        state_d = ST_R_ADDR;
                    end else begin
                        queue_en   = 1'b1;
                        queue_byte = RSP_ERR;
                    end
                end
                ST_W_ADDR: begin
                    addr_d  = i_RX_Byte;
                    state_d = ST_W_DATA;
                end
`ifdef UART_CMD_REGS_CHECKSUM_EN
                ST_W_DATA: begin
                    data_d  = i_RX_Byte;
                    state_d = ST_W_CSUM;
                end
                ST_W_CSUM: begin
                    write_en   = addr_ok(addr_q) && (i_RX_Byte == (addr_q ^ data_q));
                    write_data = data_q;
                    queue_en   = 1'b1;
                    queue_byte = write_en ? RSP_OK : RSP_ERR;
                    state_d    = ST_IDLE;
                end
`else
                ST_W_DATA: begin
                    write_en   = addr_ok(addr_q);
                    write_data = i_RX_Byte;
                    queue_en   = 1'b1;
                    queue_byte = write_en ? RSP_OK : RSP_ERR;
                    state_d    = ST_IDLE;
                end
`endif
                ST_R_ADDR: begin
                    queue_en   = 1'b1;
                    queue_byte = addr_ok(i_RX_Byte) ? rd_data : RSP_ERR;
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (write_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_q == 8'(i)) regs_d[i] = write_data;
            end
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
            timeout_d   = 1'b0;
        end

        // A fresh reply takes priority over launching the pending one, keeping o_TX_Byte stable after o_TX_DV.
        if (queue_en) begin
            pend_d    = 1'b1;
            tx_byte_d = queue_byte;
        end else if (pend_q && !i_TX_Active) begin
            pend_d  = 1'b0;
            tx_dv_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= 8'h00;
            cnt_q       <= '0;
            // NOTE: the bank is architectural state visible on o_Regs, so it is reset rather than left as RAM.
            regs_q      <= '{default: 8'h00};
            pend_q      <= 1'b0;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= 8'h00;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 8'h00;
            timeout_q   <= 1'b0;
`ifdef UART_CMD_REGS_CHECKSUM_EN
            data_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            regs_q      <= regs_d;
            pend_q      <= pend_d;
            tx_dv_q     <= tx_dv_d;
            tx_byte_q   <= tx_byte_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            timeout_q   <= timeout_d;
`ifdef UART_CMD_REGS_CHECKSUM_EN
            data_q      <= data_d;
`endif
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign o_Regs[8*g+7:8*g] = regs_q[g];
    end

    assign o_TX_DV     = tx_dv_q;
    assign o_TX_Byte   = tx_byte_q;
    assign o_Wr_Strobe = wr_strobe_q;
    assign o_Wr_Addr   = wr_addr_q;
    assign o_Timeout   = timeout_q;

endmodule

// File: tb/tb_uart_cmd_regs.sv
// Self-checking bench for uart_cmd_regs: directed scenarios plus randomized frames against a register-array model.
module tb_uart_cmd_regs;

    localparam int NUM_REGS     = 4;
    localparam int TIMEOUT_CLKS = 20;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  rx_dv = 1'b0;
    logic [7:0]            rx_byte = 8'h00;
    logic                  tx_active = 1'b0;
    logic                  tx_dv;
    logic [7:0]            tx_byte;
    logic [8*NUM_REGS-1:0] regs;
    logic                  wr_strobe;
    logic [7:0]            wr_addr;
    logic                  timeout;

    uart_cmd_regs #(.NUM_REGS(NUM_REGS), .TIMEOUT_CLKS(TIMEOUT_CLKS)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
        .i_TX_Active(tx_active), .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte),
        .o_Regs(regs), .o_Wr_Strobe(wr_strobe), .o_Wr_Addr(wr_addr), .o_Timeout(timeout)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] m_regs [NUM_REGS];
    logic [7:0] tx_log [$];
    int         strobe_cnt = 0;

    // Passive monitor of reply strobes and write strobes.
    always @(negedge clk) begin
        if (tx_dv) tx_log.push_back(tx_byte);
        if (wr_strobe) strobe_cnt++;
    end

    function automatic logic [8*NUM_REGS-1:0] model_vec();
        logic [8*NUM_REGS-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[8*i +: 8] = m_regs[i];
        return v;
    endfunction

    function automatic logic [7:0] dut_reg(input int a);
        return regs[8*a +: 8];
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Sends a complete write frame and returns the reply the protocol rules demand.
    task automatic send_write(input logic [7:0] a, input logic [7:0] d, input int gap,
                              output logic [7:0] exp_reply, output int exp_wr);
        send_byte(8'h57, gap);
        send_byte(a, gap);
        send_byte(d, gap);
`ifdef UART_CMD_REGS_CHECKSUM_EN
        send_byte(a ^ d, gap);
`endif
        if (int'(a) < NUM_REGS) begin
            m_regs[a] = d;
            exp_reply = 8'h4B;
            exp_wr    = 1;
        end else begin
            exp_reply = 8'h45;
            exp_wr    = 0;
        end
    endtask

    task automatic send_read(input logic [7:0] a, input int gap, output logic [7:0] exp_reply);
        send_byte(8'h52, gap);
        send_byte(a, gap);
        exp_reply = (int'(a) < NUM_REGS) ? m_regs[a] : 8'h45;
    endtask

    // Lets activity drain, then reports what the monitor saw and clears it.
    task automatic settle(output int n_tx, output logic [7:0] last_tx, output int n_wr);
        repeat (4) @(negedge clk);
        n_tx    = tx_log.size();
        last_tx = (n_tx > 0) ? tx_log[n_tx-1] : 8'h00;
        n_wr    = strobe_cnt;
        tx_log.delete();
        strobe_cnt = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx_dv !== 1'b0) begin errors++; $display("FAIL reset_tx_dv: got %b want 0", tx_dv); end
        checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte); end
        checks++; if (regs !== '0) begin errors++; $display("FAIL reset_regs: got %h want 0", regs); end
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); end
        checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    endtask

    task automatic test_write();
        logic [7:0] exp, got; int exp_wr, n_tx, n_wr;
        send_write(8'h02, 8'hA5, 1, exp, exp_wr);
        settle(n_tx, got, n_wr);
        checks++; if (n_tx !== 1 || got !== 8'h4B) begin errors++; $display("FAIL write_reply: got %0d x %h want 1 x 4b", n_tx, got); end
        checks++; if (n_wr !== 1) begin errors++; $display("FAIL write_strobe_cycles: got %0d want 1", n_wr); end
        checks++; if (wr_addr !== 8'h02) begin errors++; $display("FAIL write_addr: got %h want 02", wr_addr); end
        checks++; if (dut_reg(2) !== 8'hA5) begin errors++; $display("FAIL write_reg2: got %h want a5", dut_reg(2)); end
    endtask

    task automatic test_read();
        logic [7:0] exp, got; int n_tx, n_wr;
        send_read(8'h02, 1, exp);
        settle(n_tx, got, n_wr);
        checks++; if (n_tx !== 1 || got !== 8'hA5) begin errors++; $display("FAIL read_reply: got %0d x %h want 1 x a5", n_tx, got); end
        checks++; if (n_wr !== 0) begin errors++; $display("FAIL read_no_strobe: got %0d want 0", n_wr); end
    endtask

    task automatic test_bad_addr();
        logic [7:0] exp, got; int exp_wr, n_tx, n_wr;
        send_write(8'h07, 8'h11, 1, exp, exp_wr);
        settle(n_tx, got, n_wr);
        checks++; if (n_tx !== 1 || got !== 8'h45) begin errors++; $display("FAIL bad_addr_reply: got %0d x %h want 1 x 45", n_tx, got); end
        checks++; if (n_wr !== 0 || regs !== model_vec()) begin errors++; $display("FAIL bad_addr_regs: got %h strobes %0d want %h strobes 0", regs, n_wr, model_vec()); end
        send_read(8'h01, 1, exp);
        settle(n_tx, got, n_wr);
        checks++; if (n_tx !== 1 || got !== exp) begin errors++; $display("FAIL bad_addr_next_frame: got %0d x %h want 1 x %h", n_tx, got, exp); end
    endtask

    task automatic test_timeout();
        logic [7:0] exp, got; int exp_wr, n_tx, n_wr;
        send_byte(8'h57, 0);
        send_byte(8'h01, 0);
        repeat (TIMEOUT_CLKS - 3) @(negedge clk);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", timeout); end
        repeat (4) @(negedge clk);
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", timeout); end
        settle(n_tx, got, n_wr);
        checks++; if (n_tx !== 0 || n_wr !== 0) begin errors++; $display("FAIL timeout_silent: got %0d replies %0d writes want 0 0", n_tx, n_wr); end
        send_write(8'h01, 8'h33, 1, exp, exp_wr);
        settle(n_tx, got, n_wr);
        checks++; if (n_tx !== 1 || got !== 8'h4B) begin errors++; $display("FAIL timeout_rewrite_reply: got %0d x %h want 1 x 4b", n_tx, got); end
        checks++; if (dut_reg(1) !== 8'h33) begin errors++; $display("FAIL timeout_rewrite_reg: got %h want 33", dut_reg(1)); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_cleared: got %b want 0", timeout); end
    endtask

    task automatic test_tx_busy();
        logic [7:0] exp, got; int n_tx, n_wr;
        tx_active = 1'b1;
        send_read(8'h00, 1, exp);
        repeat (5) @(negedge clk);
        checks++; if (tx_log.size() !== 0) begin errors++; $display("FAIL busy_hold: got %0d replies want 0", tx_log.size()); end
        tx_active = 1'b0;
        @(negedge clk);
        checks++; if (tx_dv !== 1'b1 || tx_byte !== exp) begin errors++; $display("FAIL busy_release: got dv %b byte %h want 1 %h", tx_dv, tx_byte, exp); end
        settle(n_tx, got, n_wr);
        checks++; if (n_tx !== 1) begin errors++; $display("FAIL busy_single: got %0d replies want 1", n_tx); end
    endtask

    task automatic test_overwrite();
        logic [7:0] exp, got; int n_tx, n_wr;
        tx_active = 1'b1;
        send_byte(8'h5A, 1);
        send_read(8'h02, 1, exp);
        repeat (3) @(negedge clk);
        tx_active = 1'b0;
        settle(n_tx, got, n_wr);
        checks++; if (n_tx !== 1 || got !== exp) begin errors++; $display("FAIL overwrite_reply: got %0d x %h want 1 x %h", n_tx, got, exp); end
    endtask

`ifdef UART_CMD_REGS_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] got; int n_tx, n_wr;
        send_byte(8'h57, 1); send_byte(8'h03, 1); send_byte(8'h0F, 1); send_byte(8'h0C, 1);
        m_regs[3] = 8'h0F;
        settle(n_tx, got, n_wr);
        checks++; if (n_tx !== 1 || got !== 8'h4B || n_wr !== 1) begin errors++; $display("FAIL csum_good: got %0d x %h wr %0d want 1 x 4b wr 1", n_tx, got, n_wr); end
        checks++; if (dut_reg(3) !== 8'h0F) begin errors++; $display("FAIL csum_good_reg: got %h want 0f", dut_reg(3)); end
        send_byte(8'h57, 1); send_byte(8'h03, 1); send_byte(8'hF0, 1); send_byte(8'h00, 1);
        settle(n_tx, got, n_wr);
        checks++; if (n_tx !== 1 || got !== 8'h45 || n_wr !== 0) begin errors++; $display("FAIL csum_bad: got %0d x %h wr %0d want 1 x 45 wr 0", n_tx, got, n_wr); end
        checks++; if (dut_reg(3) !== 8'h0F) begin errors++; $display("FAIL csum_bad_reg: got %h want 0f", dut_reg(3)); end
    endtask
`endif

    task automatic test_random();
        logic [7:0] exp, got, a, d, b; int exp_wr, n_tx, n_wr, gap, kind;
        logic [7:0] last_wr_addr;
        last_wr_addr = wr_addr;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 2);
            a    = 8'($urandom_range(0, NUM_REGS + 1));
            d    = 8'($urandom);
            gap  = $urandom_range(0, 3);
            exp_wr = 0;
            if (kind == 0) begin
                send_write(a, d, gap, exp, exp_wr);
                if (exp_wr == 1) last_wr_addr = a;
            end else if (kind == 1) begin
                send_read(a, gap, exp);
            end else begin
                b = 8'($urandom);
                if (b == 8'h57 || b == 8'h52) b = 8'h00;
                send_byte(b, gap);
                exp = 8'h45;
            end
            settle(n_tx, got, n_wr);
            checks++; if (n_tx !== 1 || got !== exp) begin errors++; $display("FAIL rand_reply[%0d]: got %0d x %h want 1 x %h", f, n_tx, got, exp); end
            checks++; if (n_wr !== exp_wr) begin errors++; $display("FAIL rand_strobe[%0d]: got %0d want %0d", f, n_wr, exp_wr); end
        end
        checks++; if (regs !== model_vec()) begin errors++; $display("FAIL rand_regs: got %h want %h", regs, model_vec()); end
        checks++; if (wr_addr !== last_wr_addr) begin errors++; $display("FAIL rand_wr_addr: got %h want %h", wr_addr, last_wr_addr); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] got; int n_tx, n_wr;
        tx_active = 1'b1;
        send_byte(8'h5A, 1);
        send_byte(8'h57, 0);
        send_byte(8'h00, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        tx_active = 1'b0;
        settle(n_tx, got, n_wr);
        checks++; if (n_tx !== 0) begin errors++; $display("FAIL midreset_pending: got %0d replies want 0", n_tx); end
        checks++; if (regs !== '0) begin errors++; $display("FAIL midreset_regs: got %h want 0", regs); end
        send_byte(8'h99, 1);
        settle(n_tx, got, n_wr);
        checks++; if (n_tx !== 1 || got !== 8'h45 || n_wr !== 0) begin errors++; $display("FAIL midreset_new_frame: got %0d x %h wr %0d want 1 x 45 wr 0", n_tx, got, n_wr); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_addr();
        test_timeout();
        test_tx_busy();
        test_overwrite();
`ifdef UART_CMD_REGS_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
